// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: port identifiers and the
// per-cycle access-kind encoding.
package ram_arb_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WR   = 2'd2
  } acc_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin arbiter: on a conflict the port that was
// not granted last wins. Grant is one-hot or zero.
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic [1:0] elig_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (elig_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_gnt_i == PORT_B) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester controller for a single-port synchronous RAM with a shared
// bidirectional bus: round-robin grant, two-phase read, write turnaround.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_port_q, rd_port_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [1:0]            elig;
  logic [1:0]            gnt_oh;
  logic                  gnt_any;
  logic                  gnt_port;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  acc_e                  acc;

  // A write may not take the bus while the previous read's data phase owns it.
  assign elig[PORT_A] = a_req & ~(a_we & rd_pend_q);
  assign elig[PORT_B] = b_req & ~(b_we & rd_pend_q);

  rr_arbiter_2 u_arb (
    .elig_i     (elig),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt_oh)
  );

  always_comb begin
    gnt_any    = (|gnt_oh) & ~rst;
    gnt_port   = gnt_oh[PORT_B];
    sel_we     = gnt_port ? b_we    : a_we;
    sel_addr   = gnt_port ? b_addr  : a_addr;
    sel_wdata  = gnt_port ? b_wdata : a_wdata;
    acc        = ACC_IDLE;
    if (gnt_any) begin
      acc = sel_we ? ACC_WR : ACC_RD;
    end else begin
      acc = ACC_IDLE;
    end

    rd_pend_d  = (acc == ACC_RD);
    rd_port_d  = (acc == ACC_RD) ? gnt_port : rd_port_q;
    last_gnt_d = gnt_any ? gnt_port : last_gnt_q;
    addr_d     = gnt_any ? sel_addr : addr_q;
    rd_data_d  = rd_pend_q ? ram_data : rd_data_q;
    a_rvalid_d = rd_pend_q & (rd_port_q == PORT_A);
    b_rvalid_d = rd_pend_q & (rd_port_q == PORT_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_port_q  <= PORT_A;
      last_gnt_q <= PORT_B;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      rd_data_q  <= {DATA_WIDTH{1'b0}};
      addr_q     <= {ADDR_WIDTH{1'b0}};
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_port_q  <= rd_port_d;
      last_gnt_q <= last_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      rd_data_q  <= rd_data_d;
      addr_q     <= addr_d;
    end
  end

  assign a_gnt    = gnt_oh[PORT_A] & ~rst;
  assign b_gnt    = gnt_oh[PORT_B] & ~rst;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign rd_data  = rd_data_q;

  // With no new grant the data phase re-reads the held address, which is harmless.
  assign ram_addr = gnt_any ? sel_addr : addr_q;
  assign ram_cs   = (acc != ACC_IDLE) | rd_pend_q;
  assign ram_we   = (acc == ACC_WR);
  assign ram_oe   = rd_pend_q;
  assign ram_data = (acc == ACC_WR) ? sel_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester controller for a single-port synchronous RAM with a shared bidirectional data bus (chip-select, write-enable, output-enable; registered read).
- Requester A is the weight/activation loader and requester B is the PE array read path; either may read or write.
- The block arbitrates between A and B round-robin, sequences the RAM's two-phase read (address phase, then output-enable phase), inserts bus turnaround before a write, and returns read data tagged by requester.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 8, RAM data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request; held with stable we/addr/wdata until granted.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  port A address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_gnt  out  1  combinational; transfer accepted when a_req & a_gnt.
- a_rvalid  out  1  one-cycle pulse; rd_data holds A's read result.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid  —  same as port A, for port B.
- rd_data  out  DATA_WIDTH  registered read result, shared by both ports.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_data  inout  DATA_WIDTH  RAM data bus; driven only in a write-grant cycle, otherwise high-Z.

Behaviour:
- Registered state: rd_pend (a read was granted last cycle), rd_port (A=0/B=1), last_gnt (RR pointer), rd_data, a_rvalid, b_rvalid, held address.
- Reset values: rd_pend=0, last_gnt=B (so A wins the first conflict), rd_data=0, a_rvalid=b_rvalid=0, held address=0.
- While rst is high, both gnt outputs are 0, ram_cs/ram_we/ram_oe are 0, and ram_data is high-Z.
- Eligibility: a port is eligible if req=1, except that a write request is ineligible while rd_pend=1 (turnaround cycle).
- Arbitration:
  - If both ports are eligible, grant the port that is not last_gnt.
  - If one port is eligible, grant it.
  - At most one gnt per cycle.
  - last_gnt updates on every grant.
- Read granted in cycle N:
  - Cycle N: ram_cs=1, ram_we=0, ram_addr=addr.
  - Cycle N+1: data phase; ram_oe=1, ram_cs=1, ram_we=0. Controller captures ram_data into rd_data at the end of N+1.
  - Cycle N+2: the requesting port's rvalid=1 for one cycle.
  - Read latency is 2 cycles from the grant cycle to the rvalid cycle.
- Back-to-back reads: a new read may be granted in the data-phase cycle.
  - ram_addr carries the new address and ram_oe=1 for the previous read.
  - Result is one rvalid per read in grant order; reads sustain throughput of 1 per cycle.
- Data phase with no new grant: ram_addr holds the previous read address (the re-read is harmless), ram_cs=1, ram_oe=1.
- Write granted in cycle N:
  - Cycle N: ram_cs=1, ram_we=1, ram_oe=0, ram_data driven with wdata. Memory updates at the end of N.
  - No response is returned.
- Write immediately after a read grant is blocked for exactly one cycle. Write after write, and read after write, need no gap.
- Read-after-write to the same address returns the new data.
- Idle (no grant and rd_pend=0): ram_cs=0, ram_we=0, ram_oe=0, ram_addr held.
- Reset asserted mid-read: the pending read is dropped and no rvalid is issued for it.

Decomposition:
- Shared package ram_arb_pkg holds:
  - port-id constants PORT_A=0 and PORT_B=1;
  - the access-kind encoding (IDLE, RD, WR) used for the per-cycle phase decode.
- Sub-module rr_arbiter_2: pure combinational 2-way round-robin.
  - Inputs: eligible vector, last_gnt.
  - Output: one-hot grant.
- The top level owns the state registers, eligibility masking, RAM signal decode and the tristate driver.

Test Plan:
- A writes 0x5A to addr 3, then A reads addr 3 → write grant cycle shows ram_we=1 with ram_data=0x5A; a_rvalid is high 2 cycles after the read grant with rd_data=0x5A.
- A and B both read continuously, addrs 1 and 2 preloaded with 0x11/0x22 → grants alternate A,B,A,B starting with A after reset; rvalids alternate with 0x11/0x22; one grant per cycle.
- B read of addr 4 followed immediately by A write to addr 4 → a_gnt=0 in the cycle after B's grant and =1 in the next; B's read returns the old value; a later read returns the new value.
- Write after write to addrs 5 and 6 with no gap, then a read of addr 6 immediately → all three granted in consecutive cycles; read returns the second write's data.
- A read granted, then rst asserted in the data-phase cycle → no a_rvalid; ram_cs, ram_oe and both gnt go to 0; first conflict after reset goes to A.
- No requests for 5 cycles → ram_cs=ram_we=ram_oe=0, ram_data high-Z, rvalids 0.
